if_id_stage: RTL

Fetch stage plus IF/ID pipeline register for the 5-stage MIPS core. Holds the PC, drives the instruction-memory address, and latches the fetched word into the IF/ID register. Also decodes the latched instruction into the imm16 field and the 2-bit EXTop code consumed directly by the immediate extender (ext16) in ID. Stall, flush and branch/jump redirect are controlled by the hazard unit and the ID-stage branch logic.

---
 rtl/if_id_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register for the 5-stage MIPS core.
//
// The block holds the fetch PC and drives the word address of a combinational
// instruction ROM. Each cycle it latches the fetched word and its PC into the
// IF/ID register. It also decodes the latched word into the imm16 field and
// the EXTop code used by the ID-stage immediate extender (ext16).
//
// Ports:
//   clk              rising-edge clock for all state
//   reset_n          asynchronous active-low reset
//   stall            hazard unit: hold the PC and the IF/ID register
//   flush            load a bubble into IF/ID (takes priority over stall)
//   redirect         ID-stage branch/jump taken; the PC loads redirect_target
//   redirect_target  next PC on redirect (bits [1:0] are ignored)
//   imem_addr        word address into the instruction ROM
//   imem_rdata       instruction at imem_addr, available in the same cycle
//   if_pc            current fetch PC
//   id_instr         IF/ID instruction
//   id_pc            IF/ID PC
//   id_pc8           id_pc + 8, the jal/jalr link value
//   id_valid         IF/ID holds a real instruction
//   id_imm16         id_instr[15:0]
//   id_EXTop         extender control: 00 zero, 01 sign, 10 upper, 11 zero output
module if_id_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter int unsigned IM_ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 redirect,
  input  logic [31:0]          redirect_target,
  output logic [IM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          if_pc,
  output logic [31:0]          id_instr,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_pc8,
  output logic                 id_valid,
  output logic [15:0]          id_imm16,
  output logic [1:0]           id_EXTop
);

  // Extender control encodings.
  localparam logic [1:0] ExtZero  = 2'b00;
  localparam logic [1:0] ExtSign  = 2'b01;
  localparam logic [1:0] ExtUpper = 2'b10;
  localparam logic [1:0] ExtNone  = 2'b11;

  // State registers.
  logic [31:0] pc_q,       pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q,    id_pc_d;
  logic        id_valid_q, id_valid_d;

  // The word address ignores the byte offset and all PC bits above the ROM.
  assign imem_addr = pc_q[IM_ADDR_W+1:2];

  // Redirect targets are word aligned; the discarded low bits are kept here
  // only to mark them as intentionally unused.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^redirect_target[1:0];

  // PC next state. A stall wins over redirect: the branch sits in ID and
  // reasserts redirect once the stall clears.
  always_comb begin
    pc_d = pc_q;
    if (!stall) begin
      if (redirect) begin
        pc_d = {redirect_target[31:2], 2'b00};
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  // IF/ID next state, priority flush > stall > load. A redirect does not
  // flush: the word fetched in the redirect cycle is the delay slot.
  always_comb begin
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    if (flush) begin
      id_instr_d = 32'h0000_0000;
      id_pc_d    = 32'h0000_0000;
      id_valid_d = 1'b0;
    end else if (!stall) begin
      id_instr_d = imem_rdata;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= PC_RESET;
      id_instr_q <= 32'h0000_0000;
      id_pc_q    <= 32'h0000_0000;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end

  // Immediate extender control from the latched opcode. A bubble holds
  // id_instr=0, which decodes as R-type and yields ExtNone.
  logic [5:0] id_opcode;
  assign id_opcode = id_instr_q[31:26];

  always_comb begin
    id_EXTop = ExtNone;
    case (id_opcode)
      // andi, ori, xori
      6'h0C, 6'h0D, 6'h0E: id_EXTop = ExtZero;
      // addi, addiu, slti, sltiu
      6'h08, 6'h09, 6'h0A, 6'h0B: id_EXTop = ExtSign;
      // lb, lh, lw, lbu, lhu
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: id_EXTop = ExtSign;
      // sb, sh, sw
      6'h28, 6'h29, 6'h2B: id_EXTop = ExtSign;
      // regimm, beq, bne, blez, bgtz
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: id_EXTop = ExtSign;
      // lui
      6'h0F: id_EXTop = ExtUpper;
      // R-type, j, jal and everything else
      default: id_EXTop = ExtNone;
    endcase
  end

  assign if_pc    = pc_q;
  assign id_instr = id_instr_q;
  assign id_pc    = id_pc_q;
  assign id_valid = id_valid_q;
  assign id_pc8   = id_pc_q + 32'd8;
  assign id_imm16 = id_instr_q[15:0];

endmodule
